adv7513_i2c_slave: RTL and testbench

I2C target that answers the same register protocol our ADV7513 register-read/write masters issue: 7-bit chip address, one register-address byte, one or more data bytes. It holds a 256×8 register file and supports the following transfers:
- writes;
- combined reads (write pointer, repeated START, read);
- auto-increment bursts.

It serves as the bus-functional ADV7513 model in master testbenches and as an on-FPGA debug target sharing the `sda`/`scl` pins.

---
 rtl/adv7513_i2c_slave_pkg.sv | 20 ++
 rtl/adv7513_i2c_slave_line_sync.sv | 48 ++++
 rtl/adv7513_i2c_slave.sv | 199 +++++++++++++++++++
 tb/tb_adv7513_i2c_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adv7513_i2c_slave_pkg.sv
// Shared I2C definitions for the ADV7513 register-protocol target and the
// masters that talk to it: byte geometry, R/W bit position and the target's
// state encoding.
package adv7513_i2c_slave_pkg;

    localparam int         I2C_BYTE_BITS = 8;
    localparam int         I2C_RW_BIT    = 0;
    localparam logic [3:0] LAST_BIT      = 4'(I2C_BYTE_BITS - 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WR       = 4'd5;
    localparam logic [3:0] ST_WR_ACK   = 4'd6;
    localparam logic [3:0] ST_RD       = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;

endpackage

// File: rtl/adv7513_i2c_slave_line_sync.sv
// i2c_line_sync: 2-FF synchronizers on scl/sda plus a previous-value flop,
// producing bus events in the clk domain.
//   clk, reset        : system clock, synchronous active-high reset
//   scl, sda          : raw bus lines
//   scl_rise/scl_fall : synced scl edges (one-cycle pulses)
//   start_det         : synced sda fell while scl high
//   stop_det          : synced sda rose while scl high
//   sda_s             : synchronized sda level
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic scl_m, scl_s, scl_p;
    logic sda_m, sda_p;

    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_p <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_m <= scl;
            scl_s <= scl_m;
            scl_p <= scl_s;
            sda_m <= sda;
            sda_s <= sda_m;
            sda_p <= sda_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_p;
    assign scl_fall  = ~scl_s &  scl_p;
    assign start_det =  scl_s &  scl_p &  sda_p & ~sda_s;
    assign stop_det  =  scl_s &  scl_p & ~sda_p &  sda_s;

endmodule

// File: rtl/adv7513_i2c_slave.sv
// adv7513_i2c_slave: I2C target with a 256x8 register file answering the
// ADV7513 register protocol (chip address, pointer byte, data bytes with
// auto-increment; combined reads via repeated START).
//   clk, reset     : system clock, synchronous active-high reset
//   scl            : I2C clock (input only, no stretching)
//   sda            : open-drain data; only ever driven low
//   host_addr      : local readback address
//   host_rdata     : reg[host_addr], one cycle latency
//   wr_strobe      : one-cycle pulse per byte written over I2C
//   wr_addr/wr_data: address/data of the last I2C write
//   busy           : addressed transaction in progress
module adv7513_i2c_slave
    import adv7513_i2c_slave_pkg::*;
#(
    parameter logic [6:0] CHIP_ADDR = 7'h39
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] ptr;
    logic [7:0] byte_in;
    logic       sda_oe;
    logic       rw;
    logic       mem_we;
    logic [7:0] mem [0:255];

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign sda     = sda_oe ? 1'b0 : 1'bz;
    assign byte_in = {shreg[6:0], sda_s};

    // START/STOP need scl high on two samples while a rise needs it low on
    // the previous one, so a write-completing rise never coincides with them.
    assign mem_we = !reset && (state == ST_WR) && scl_rise && (bit_cnt == LAST_BIT);

    // Register file kept outside the reset domain so it can map to RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[ptr] <= byte_in;
    end

    always_ff @(posedge clk) begin
        if (reset)
            host_rdata <= '0;
        else
            host_rdata <= mem[host_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shreg <= byte_in;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (byte_in[7:1] == CHIP_ADDR) begin
                                rw    <= byte_in[I2C_RW_BIT];
                                busy  <= 1'b1;
                                state <= ST_ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // ACK states: sda_oe doubles as the phase flag; the first
                    // fall pulls sda low, the second ends the ACK bit.
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            state   <= ST_RD;
                            bit_cnt <= '0;
                            shreg   <= mem[ptr];
                            sda_oe  <= ~mem[ptr][7];
                        end else begin
                            sda_oe  <= 1'b0;
                            state   <= ST_PTR;
                            bit_cnt <= '0;
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shreg <= byte_in;
                        if (bit_cnt == LAST_BIT) begin
                            ptr     <= byte_in;
                            bit_cnt <= '0;
                            state   <= ST_PTR_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_WR;
                        end
                    end
                    ST_WR: if (scl_rise) begin
                        shreg <= byte_in;
                        if (bit_cnt == LAST_BIT) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= byte_in;
                            ptr       <= ptr + 8'd1;
                            bit_cnt   <= '0;
                            state     <= ST_WR_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    // Bit 7 went out when the byte was loaded; each later fall
                    // rotates the next bit into the MSB position and drives it.
                    ST_RD: begin
                        if (scl_rise) begin
                            if (bit_cnt == LAST_BIT) begin
                                ptr     <= ptr + 8'd1;
                                bit_cnt <= 4'd8;
                                state   <= ST_RD_ACK;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall) begin
                            shreg  <= {shreg[6:0], shreg[7]};
                            sda_oe <= ~shreg[6];
                        end
                    end
                    // bit_cnt 8: releasing for the master's bit; 9: ACK seen.
                    ST_RD_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else begin
                                state   <= ST_RD;
                                bit_cnt <= '0;
                                shreg   <= mem[ptr];
                                sda_oe  <= ~mem[ptr][7];
                            end
                        end else if (scl_rise) begin
                            if (sda_s)
                                state <= ST_IDLE;
                            else
                                bit_cnt <= 4'd9;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adv7513_i2c_slave.sv
// Directed bench for adv7513_i2c_slave: bit-banged I2C master, a register
// model (byte array + pointer + expected-write queue) and a per-cycle
// compare of wr_strobe/wr_addr/wr_data and host_rdata against that model.
module tb_adv7513_i2c_slave;

    localparam int Q = 10;  // quarter SCL bit period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_rdata, wr_addr, wr_data;
    logic       wr_strobe, busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    adv7513_i2c_slave #(.CHIP_ADDR(7'h39)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Model: register contents as the bus protocol defines them.
    logic [7:0]  mm [256];
    logic [7:0]  mptr = 8'h00;
    logic [15:0] expq [$];

    // Image of what the register file holds, advanced as writes are observed.
    logic [7:0] sh [256];
    bit         shk [256];
    logic [7:0] hr_exp = 8'h00;
    bit         hr_ok = 1'b0;

    always @(posedge clk) begin
        hr_exp <= reset ? 8'h00 : sh[host_addr];
        hr_ok  <= reset || shk[host_addr];
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (hr_ok)
            check("host_rdata", {24'h0, host_rdata}, {24'h0, hr_exp});
        if (wr_strobe) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_strobe: got write %0h=%0h want none", wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                check("wr_addr", {24'h0, wr_addr}, {24'h0, e[15:8]});
                check("wr_data", {24'h0, wr_data}, {24'h0, e[7:0]});
                sh[e[15:8]]  = e[7:0];
                shk[e[15:8]] = 1'b1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic drive, output logic seen);
        m_sda_low = ~drive;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        seen = sda;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_sda_low = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--)
            bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~ack, s);
    endtask

    task automatic write_txn(input logic [7:0] p, input int n, input logic [7:0] d0, input logic [7:0] d1);
        logic a;
        logic [7:0] d;
        i2c_start();
        send_byte(8'h72, a);
        check("wr_addr_ack", {31'h0, a}, 32'h1);
        check("busy_set", {31'h0, busy}, 32'h1);
        send_byte(p, a);
        check("wr_ptr_ack", {31'h0, a}, 32'h1);
        mptr = p;
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? d0 : d1;
            expq.push_back({mptr, d});
            mm[mptr] = d;
            mptr = mptr + 8'd1;
            send_byte(d, a);
            check("wr_data_ack", {31'h0, a}, 32'h1);
        end
        i2c_stop();
    endtask

    task automatic read_txn(input bit with_ptr, input logic [7:0] p, input int n,
                            output logic [7:0] b0, output logic [7:0] b1);
        logic a;
        logic [7:0] b;
        b0 = 8'h00;
        b1 = 8'h00;
        i2c_start();
        if (with_ptr) begin
            send_byte(8'h72, a);
            check("rd_addr_w_ack", {31'h0, a}, 32'h1);
            send_byte(p, a);
            check("rd_ptr_ack", {31'h0, a}, 32'h1);
            mptr = p;
            i2c_start();
        end
        send_byte(8'h73, a);
        check("rd_addr_r_ack", {31'h0, a}, 32'h1);
        for (int i = 0; i < n; i++) begin
            recv_byte(b, i < n - 1);
            check("rd_model", {24'h0, b}, {24'h0, mm[mptr]});
            mptr = mptr + 8'd1;
            if (i == 0) b0 = b; else b1 = b;
        end
    endtask

    initial begin
        logic       a, s, seen;
        logic [7:0] b0, b1;
        int         n;

        tick(5);
        reset = 1'b0;
        tick(3);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_strobe", {31'h0, wr_strobe}, 32'h0);
        check("rst_wr_addr", {24'h0, wr_addr}, 32'h0);
        check("rst_wr_data", {24'h0, wr_data}, 32'h0);
        check("rst_rdata", {24'h0, host_rdata}, 32'h0);
        check("rst_sda", {31'h0, sda}, 32'h1);

        // write burst
        write_txn(8'h10, 2, 8'hA5, 8'h5A);
        check("burst_busy_clr", {31'h0, busy}, 32'h0);
        host_addr = 8'h11;
        tick(3);
        check("burst_rdata", {24'h0, host_rdata}, 32'h5A);
        check("burst_last_addr", {24'h0, wr_addr}, 32'h11);
        check("burst_last_data", {24'h0, wr_data}, 32'h5A);

        // combined read, ACK then NACK
        read_txn(1'b1, 8'h10, 2, b0, b1);
        check("cr_byte0", {24'h0, b0}, 32'hA5);
        check("cr_byte1", {24'h0, b1}, 32'h5A);
        check("cr_busy_after_nack", {31'h0, busy}, 32'h1);
        i2c_stop();
        check("cr_busy_after_stop", {31'h0, busy}, 32'h0);

        // wrong chip address; later bytes must be ignored
        i2c_start();
        send_byte(8'h74, a);
        check("wa_nack", {31'h0, a}, 32'h0);
        check("wa_busy", {31'h0, busy}, 32'h0);
        send_byte(8'h10, a);
        check("wa_ptr_nack", {31'h0, a}, 32'h0);
        send_byte(8'h99, a);
        check("wa_data_nack", {31'h0, a}, 32'h0);
        i2c_stop();
        check("wa_busy_end", {31'h0, busy}, 32'h0);

        // pointer wrap, then read continuing from the wrapped pointer
        write_txn(8'h01, 1, 8'hC3, 8'h00);
        write_txn(8'hFF, 2, 8'h11, 8'h22);
        host_addr = 8'hFF;
        tick(3);
        check("wrap_ff", {24'h0, host_rdata}, 32'h11);
        host_addr = 8'h00;
        tick(3);
        check("wrap_00", {24'h0, host_rdata}, 32'h22);
        read_txn(1'b0, 8'h00, 1, b0, b1);
        check("wrap_read_01", {24'h0, b0}, 32'hC3);
        i2c_stop();

        // host read colliding with an I2C write to the same address
        write_txn(8'h20, 1, 8'h44, 8'h00);
        host_addr = 8'h20;
        tick(3);
        i2c_start();
        send_byte(8'h72, a);
        check("col_addr_ack", {31'h0, a}, 32'h1);
        send_byte(8'h20, a);
        check("col_ptr_ack", {31'h0, a}, 32'h1);
        expq.push_back({8'h20, 8'h77});
        mm[8'h20] = 8'h77;
        mptr = 8'h21;
        seen = 1'b0;
        fork
            send_byte(8'h77, a);
            begin
                n = 0;
                while (n < 600 && !seen) begin
                    @(negedge clk);
                    if (wr_strobe) seen = 1'b1;
                    n++;
                end
                check("col_strobe_seen", {31'h0, seen}, 32'h1);
                if (seen) begin
                    check("col_old", {24'h0, host_rdata}, 32'h44);
                    @(negedge clk);
                    check("col_new", {24'h0, host_rdata}, 32'h77);
                end
            end
        join
        check("col_data_ack", {31'h0, a}, 32'h1);
        i2c_stop();

        // reset during bit 4 of a read byte driving 0 (0x0F: bits 7..4 low)
        write_txn(8'h30, 1, 8'h0F, 8'h00);
        i2c_start();
        send_byte(8'h72, a);
        send_byte(8'h30, a);
        check("rr_ptr_ack", {31'h0, a}, 32'h1);
        i2c_start();
        send_byte(8'h73, a);
        check("rr_addr_ack", {31'h0, a}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            bit_xfer(1'b1, s);
            check("rr_hi_bit", {31'h0, s}, 32'h0);
        end
        m_sda_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        check("rr_bit4_low", {31'h0, sda}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rr_sda_released", {31'h0, sda}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        mptr = 8'h00;
        tick(Q);
        scl = 1'b0;
        tick(Q);
        i2c_stop();
        check("rr_busy", {31'h0, busy}, 32'h0);
        check("rr_wr_addr", {24'h0, wr_addr}, 32'h0);
        read_txn(1'b0, 8'h00, 1, b0, b1);
        check("rr_ptr_zero", {24'h0, b0}, 32'h22);
        i2c_stop();
        host_addr = 8'h30;
        tick(3);
        check("rr_preserved", {24'h0, host_rdata}, 32'h0F);

        tick(10);
        check("expq_drained", expq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
